// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse host master.
// MOUSE_EXPLORER_EN enables the second (explorer) ID knock and 5-button packets.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_STEP,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_STREAM,
    ST_FAILED
  } state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES  = 8'hE8;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] BAT_OK = 8'hAA;

  localparam logic [7:0] ID_STD      = 8'h00;
  localparam logic [7:0] ID_WHEEL    = 8'h03;
  localparam logic [7:0] ID_EXPLORER = 8'h04;

`ifdef MOUSE_EXPLORER_EN
  localparam bit EXPLORER_EN = 1'b1;
`else
  localparam bit EXPLORER_EN = 1'b0;
`endif

  // Init ROM step map: 0..15 main sequence, 16..23 explorer knock.
  localparam int STEP_W = 5;
  localparam logic [STEP_W-1:0] STEP_ID1        = 5'd10;
  localparam logic [STEP_W-1:0] STEP_FINAL_RATE = 5'd11;
  localparam logic [STEP_W-1:0] STEP_KNOCK2     = 5'd16;
  localparam logic [STEP_W-1:0] STEP_ID2        = 5'd23;

  typedef struct packed {
    logic       send;   // 1: transmit cmd then await resp; 0: await resp only
    logic [7:0] cmd;
    logic [7:0] resp;
    logic       is_id;  // response is a device ID, not a fixed byte
    logic       last;
  } rom_entry_t;

  function automatic logic id_ok(input logic [7:0] id);
    return (id == ID_STD) || (id == ID_WHEEL) || (EXPLORER_EN && (id == ID_EXPLORER));
  endfunction

endpackage

// File: rtl/ps2_mouse_init_rom.sv
// Init command table: step index -> {send flag, command, expected response, ID flag, last flag}.
// Steps 16..23 (explorer knock) are only reached when MOUSE_EXPLORER_EN is defined.
module ps2_mouse_init_rom
  import ps2_mouse_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100,
  parameter logic [7:0] RESOLUTION  = 8'h02
) (
  input  logic [STEP_W-1:0] step_i,
  output rom_entry_t        entry_o
);

  function automatic rom_entry_t tx(input logic [7:0] cmd, input logic last);
    return '{send: 1'b1, cmd: cmd, resp: ACK, is_id: 1'b0, last: last};
  endfunction

  function automatic rom_entry_t rx(input logic [7:0] resp, input logic is_id);
    return '{send: 1'b0, cmd: 8'h00, resp: resp, is_id: is_id, last: 1'b0};
  endfunction

  always_comb begin
    entry_o = rx(8'h00, 1'b0);
    unique case (step_i)
      5'd0:  entry_o = tx(CMD_RESET, 1'b0);
      5'd1:  entry_o = rx(BAT_OK, 1'b0);
      5'd2:  entry_o = rx(ID_STD, 1'b0);
      5'd3:  entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd4:  entry_o = tx(8'hC8, 1'b0);
      5'd5:  entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd6:  entry_o = tx(8'h64, 1'b0);
      5'd7:  entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd8:  entry_o = tx(8'h50, 1'b0);
      5'd9:  entry_o = tx(CMD_GET_ID, 1'b0);
      5'd10: entry_o = rx(8'h00, 1'b1);
      5'd11: entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd12: entry_o = tx(SAMPLE_RATE, 1'b0);
      5'd13: entry_o = tx(CMD_SET_RES, 1'b0);
      5'd14: entry_o = tx(RESOLUTION, 1'b0);
      5'd15: entry_o = tx(CMD_ENABLE, 1'b1);
      5'd16: entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd17: entry_o = tx(8'hC8, 1'b0);
      5'd18: entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd19: entry_o = tx(8'hC8, 1'b0);
      5'd20: entry_o = tx(CMD_SET_RATE, 1'b0);
      5'd21: entry_o = tx(8'h50, 1'b0);
      5'd22: entry_o = tx(CMD_GET_ID, 1'b0);
      5'd23: entry_o = rx(8'h00, 1'b1);
      default: entry_o = rx(8'h00, 1'b0);
    endcase
  end

endmodule

// File: rtl/ps2_mouse_master_ext.sv
// PS/2 mouse host master: ROM-driven init with timeouts/retries, then 3/4-byte stream decode.
// MOUSE_EXPLORER_EN adds the explorer knock and ID 04 packet format.
module ps2_mouse_master_ext
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES    = 5000000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter logic [7:0]  SAMPLE_RATE         = 8'd100,
  parameter logic [7:0]  RESOLUTION          = 8'h02
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic [1:0] MOUSE_BUTTONS_EXT,
  output logic [7:0] DEVICE_ID,
  output logic       INIT_DONE,
  output logic       INIT_FAIL,
  output logic       SEND_INTERRUPT
);

  localparam int unsigned CNT_MAX = (INIT_WAIT_CYCLES > RESP_TIMEOUT_CYCLES) ?
                                    INIT_WAIT_CYCLES : RESP_TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT     = CW'(RESP_TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  state_e            state_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        bidx_q;
  logic [7:0]        sh0_q, sh1_q, sh2_q;
  logic              send_byte_q, read_en_q, init_done_q, init_fail_q, irq_q;
  logic [7:0]        byte_to_send_q, status_q, dx_q, dy_q, dz_q, dev_id_q;
  logic [7:0]        dz_d;
  rom_entry_t        rom;
  logic              byte_good, wait_timeout, resp_ok, init_err, pkt_last;

  ps2_mouse_init_rom #(
    .SAMPLE_RATE(SAMPLE_RATE),
    .RESOLUTION (RESOLUTION)
  ) u_rom (
    .step_i (step_q),
    .entry_o(rom)
  );

  assign cnt_d        = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign retry_d      = retry_q + RW'(1);
  assign byte_good    = (BYTE_ERROR_CODE == 2'b00);
  assign wait_timeout = (cnt_q >= TIMEOUT);
  assign resp_ok      = byte_good && (rom.is_id ? id_ok(BYTE_READ) : (BYTE_READ == rom.resp));
  assign pkt_last     = (bidx_q == ((dev_id_q == ID_STD) ? 2'd2 : 2'd3));

  // Any failure during init; a byte arriving on the terminal count is not a timeout.
  assign init_err = ((state_q == ST_WAIT_SENT) && !BYTE_SENT && wait_timeout) ||
                    ((state_q == ST_WAIT_RESP) && (BYTE_READY ? !resp_ok : wait_timeout));

  always_comb begin
    step_d = step_q + STEP_W'(1);
    if (EXPLORER_EN && (step_q == STEP_ID1) && (BYTE_READ == ID_WHEEL)) step_d = STEP_KNOCK2;
    else if (step_q == STEP_ID2) step_d = STEP_FINAL_RATE;
  end

`ifdef MOUSE_EXPLORER_EN
  logic [1:0] buttons_q;
  assign dz_d = (dev_id_q == ID_EXPLORER) ? {{4{BYTE_READ[3]}}, BYTE_READ[3:0]} : BYTE_READ;
  assign MOUSE_BUTTONS_EXT = buttons_q;
`else
  assign dz_d = BYTE_READ;
  assign MOUSE_BUTTONS_EXT = 2'b00;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_WAIT_INIT;
      cnt_q          <= '0;
      retry_q        <= '0;
      step_q         <= '0;
      bidx_q         <= '0;
      sh0_q          <= '0;
      sh1_q          <= '0;
      sh2_q          <= '0;
      send_byte_q    <= 1'b0;
      byte_to_send_q <= '0;
      read_en_q      <= 1'b0;
      init_done_q    <= 1'b0;
      init_fail_q    <= 1'b0;
      irq_q          <= 1'b0;
      status_q       <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      dz_q           <= '0;
      dev_id_q       <= '0;
`ifdef MOUSE_EXPLORER_EN
      buttons_q      <= '0;
`endif
    end else begin
      send_byte_q <= 1'b0;
      irq_q       <= 1'b0;
      if (init_err) begin
        read_en_q <= 1'b0;
        cnt_q     <= '0;
        retry_q   <= retry_d;
        if (retry_d >= RETRY_LIMIT) begin
          init_fail_q <= 1'b1;
          state_q     <= ST_FAILED;
        end else begin
          state_q <= ST_WAIT_INIT;
        end
      end else begin
        unique case (state_q)
          ST_WAIT_INIT: begin
            if (cnt_q >= INIT_LAST) begin
              cnt_q   <= '0;
              step_q  <= '0;
              state_q <= ST_STEP;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_STEP: begin
            cnt_q <= '0;
            if (rom.send) begin
              send_byte_q    <= 1'b1;
              byte_to_send_q <= rom.cmd;
              state_q        <= ST_WAIT_SENT;
            end else begin
              read_en_q <= 1'b1;
              state_q   <= ST_WAIT_RESP;
            end
          end
          ST_WAIT_SENT: begin
            if (BYTE_SENT) begin
              cnt_q     <= '0;
              read_en_q <= 1'b1;
              state_q   <= ST_WAIT_RESP;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_WAIT_RESP: begin
            if (BYTE_READY) begin
              if (rom.is_id) dev_id_q <= BYTE_READ;
              if (rom.last) begin
                init_done_q <= 1'b1;
                retry_q     <= '0;
                bidx_q      <= '0;
                cnt_q       <= '0;
                state_q     <= ST_STREAM;
              end else begin
                read_en_q <= 1'b0;
                step_q    <= step_d;
                state_q   <= ST_STEP;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_STREAM: begin
            if (BYTE_READY) begin
              if (!byte_good) begin
                init_done_q <= 1'b0;
                read_en_q   <= 1'b0;
                retry_q     <= '0;
                bidx_q      <= '0;
                cnt_q       <= '0;
                state_q     <= ST_WAIT_INIT;
              end else if ((bidx_q != 2'd0) || BYTE_READ[3]) begin
                // Byte 0 without its always-one bit is dropped silently (resync).
                cnt_q <= '0;
                if (bidx_q == 2'd0) sh0_q <= BYTE_READ;
                else if (bidx_q == 2'd1) sh1_q <= BYTE_READ;
                else if (bidx_q == 2'd2) sh2_q <= BYTE_READ;
                if (pkt_last) begin
                  bidx_q   <= '0;
                  irq_q    <= 1'b1;
                  status_q <= sh0_q;
                  dx_q     <= sh1_q;
                  if (dev_id_q == ID_STD) begin
                    dy_q <= BYTE_READ;
                    dz_q <= 8'h00;
`ifdef MOUSE_EXPLORER_EN
                    buttons_q <= 2'b00;
`endif
                  end else begin
                    dy_q <= sh2_q;
                    dz_q <= dz_d;
`ifdef MOUSE_EXPLORER_EN
                    buttons_q <= (dev_id_q == ID_EXPLORER) ? BYTE_READ[5:4] : 2'b00;
`endif
                  end
                end else begin
                  bidx_q <= bidx_q + 2'd1;
                end
              end
            end else if (bidx_q != 2'd0) begin
              if (wait_timeout) bidx_q <= '0;
              else cnt_q <= cnt_d;
            end
          end
          default: begin
            read_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SEND_BYTE      = send_byte_q;
  assign BYTE_TO_SEND   = byte_to_send_q;
  assign READ_ENABLE    = read_en_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign MOUSE_DZ       = dz_q;
  assign DEVICE_ID      = dev_id_q;
  assign INIT_DONE      = init_done_q;
  assign INIT_FAIL      = init_fail_q;
  assign SEND_INTERRUPT = irq_q;

endmodule

// File: tb/tb_ps2_mouse_master_ext.sv
// Directed bench for ps2_mouse_master_ext: behavioural mouse answers init commands, then streams packets.
module tb_ps2_mouse_master_ext;

  localparam int INIT_WAIT = 20;
  localparam int TIMEOUT   = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_byte, byte_sent, read_enable, byte_ready;
  logic [7:0] byte_to_send, byte_read;
  logic [1:0] byte_error_code, buttons_ext;
  logic [7:0] status, dx, dy, dz, device_id;
  logic       init_done, init_fail, send_interrupt;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_cnt  = 0;

  ps2_mouse_master_ext #(
    .INIT_WAIT_CYCLES   (INIT_WAIT),
    .RESP_TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES        (3),
    .SAMPLE_RATE        (8'd100),
    .RESOLUTION         (8'h02)
  ) dut (
    .CLK              (clk),
    .RESET_N          (rst_n),
    .SEND_BYTE        (send_byte),
    .BYTE_TO_SEND     (byte_to_send),
    .BYTE_SENT        (byte_sent),
    .READ_ENABLE      (read_enable),
    .BYTE_READ        (byte_read),
    .BYTE_ERROR_CODE  (byte_error_code),
    .BYTE_READY       (byte_ready),
    .MOUSE_STATUS     (status),
    .MOUSE_DX         (dx),
    .MOUSE_DY         (dy),
    .MOUSE_DZ         (dz),
    .MOUSE_BUTTONS_EXT(buttons_ext),
    .DEVICE_ID        (device_id),
    .INIT_DONE        (init_done),
    .INIT_FAIL        (init_fail),
    .SEND_INTERRUPT   (send_interrupt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (send_interrupt) irq_cnt <= irq_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_send"},   send_byte,      0);
    check_eq({tag, "_tx"},     byte_to_send,   0);
    check_eq({tag, "_rden"},   read_enable,    0);
    check_eq({tag, "_status"}, status,         0);
    check_eq({tag, "_dx"},     dx,             0);
    check_eq({tag, "_dy"},     dy,             0);
    check_eq({tag, "_dz"},     dz,             0);
    check_eq({tag, "_btn"},    buttons_ext,    0);
    check_eq({tag, "_id"},     device_id,      0);
    check_eq({tag, "_done"},   init_done,      0);
    check_eq({tag, "_fail"},   init_fail,      0);
    check_eq({tag, "_irq"},    send_interrupt, 0);
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_sent = 1'b0; byte_ready = 1'b0; byte_read = 8'h00; byte_error_code = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] err);
    repeat (3) @(negedge clk);
    byte_read = b; byte_error_code = err; byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0; byte_error_code = 2'b00;
  endtask

  // Waits for a command, checks it, acknowledges transmission, answers with resp.
  task automatic mouse_cmd(input logic [7:0] exp_cmd, input logic [7:0] resp);
    bit seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (send_byte) begin seen = 1; break; end
    end
    if (!seen) begin
      check_eq("cmd_timeout", 0, 1);
      return;
    end
    check_eq("cmd", byte_to_send, exp_cmd);
    byte_sent = 1'b1;
    @(negedge clk);
    byte_sent = 1'b0;
    rx(resp, 2'b00);
  endtask

  task automatic knock(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    mouse_cmd(8'hF3, 8'hFA); mouse_cmd(r1, 8'hFA);
    mouse_cmd(8'hF3, 8'hFA); mouse_cmd(r2, 8'hFA);
    mouse_cmd(8'hF3, 8'hFA); mouse_cmd(r3, 8'hFA);
  endtask

  task automatic init_head(input logic [7:0] id);
    mouse_cmd(8'hFF, 8'hFA);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    knock(8'hC8, 8'h64, 8'h50);
    mouse_cmd(8'hF2, 8'hFA);
    rx(id, 2'b00);
  endtask

  task automatic init_tail();
    mouse_cmd(8'hF3, 8'hFA); mouse_cmd(8'h64, 8'hFA);
    mouse_cmd(8'hE8, 8'hFA); mouse_cmd(8'h02, 8'hFA);
    mouse_cmd(8'hF4, 8'hFA);
    repeat (2) @(negedge clk);
  endtask

  task automatic packet4(input logic [7:0] b0, b1, b2, b3, input logic [7:0] exp_dz);
    rx(b0, 2'b00); rx(b1, 2'b00); rx(b2, 2'b00); rx(b3, 2'b00);
    check_eq("p4_irq", send_interrupt, 1);
    check_eq("p4_status", status, b0);
    check_eq("p4_dx", dx, b1);
    check_eq("p4_dy", dy, b2);
    check_eq("p4_dz", dz, exp_dz);
  endtask

  int base;
  int n;

  initial begin
    byte_sent = 1'b0; byte_ready = 1'b0; byte_read = 8'h00; byte_error_code = 2'b00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Nominal 3-byte mouse; FF must not appear before the power-up wait.
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (send_byte) break;
    end
    check_eq("init_wait_min", (n >= INIT_WAIT) ? 1 : 0, 1);
    check_eq("first_cmd", byte_to_send, 8'hFF);
    byte_sent = 1'b1; @(negedge clk); byte_sent = 1'b0;
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    knock(8'hC8, 8'h64, 8'h50);
    mouse_cmd(8'hF2, 8'hFA);
    rx(8'h00, 2'b00);
    init_tail();
    check_eq("nom_done", init_done, 1);
    check_eq("nom_id", device_id, 8'h00);
    check_eq("nom_rden", read_enable, 1);
    base = irq_cnt;
    rx(8'h08, 2'b00); rx(8'h05, 2'b00); rx(8'hFB, 2'b00);
    check_eq("nom_irq", send_interrupt, 1);
    check_eq("nom_status", status, 8'h08);
    check_eq("nom_dx", dx, 8'h05);
    check_eq("nom_dy", dy, 8'hFB);
    check_eq("nom_dz", dz, 8'h00);
    @(negedge clk);
    check_eq("nom_irq_low", send_interrupt, 0);
    @(negedge clk);
    check_eq("nom_irq_count", irq_cnt - base, 1);

    // Resync on bad byte 0, then drop a partial packet after a long gap.
    base = irq_cnt;
    rx(8'h00, 2'b00);
    rx(8'h08, 2'b00); rx(8'h01, 2'b00);
    repeat (TIMEOUT + 30) @(negedge clk);
    rx(8'h08, 2'b00); rx(8'h02, 2'b00); rx(8'h03, 2'b00);
    check_eq("gap_dx", dx, 8'h02);
    check_eq("gap_dy", dy, 8'h03);
    repeat (2) @(negedge clk);
    check_eq("gap_irq_count", irq_cnt - base, 1);
    check_eq("gap_done", init_done, 1);

    // Receive error on DX restarts init after the power-up wait.
    rx(8'h08, 2'b00);
    rx(8'h11, 2'b01);
    check_eq("err_done", init_done, 0);
    check_eq("err_rden", read_enable, 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (send_byte) break;
    end
    check_eq("err_wait_min", (n >= INIT_WAIT) ? 1 : 0, 1);
    check_eq("err_resend", byte_to_send, 8'hFF);
    check_eq("err_resend_pulse", send_byte, 1);

    // Wheel mouse: 4-byte framing over three packets, then async reset mid-packet.
    do_reset();
    init_head(8'h03);
`ifdef MOUSE_EXPLORER_EN
    knock(8'hC8, 8'hC8, 8'h50);
    mouse_cmd(8'hF2, 8'hFA);
    rx(8'h03, 2'b00);
`endif
    init_tail();
    check_eq("whl_done", init_done, 1);
    check_eq("whl_id", device_id, 8'h03);
    base = irq_cnt;
    packet4(8'h09, 8'h01, 8'h02, 8'hFF, 8'hFF);
    packet4(8'h08, 8'h10, 8'h20, 8'h01, 8'h01);
    packet4(8'h0A, 8'hFF, 8'hFE, 8'h7F, 8'h7F);
    check_eq("whl_btn", buttons_ext, 0);
    repeat (2) @(negedge clk);
    check_eq("whl_irq_count", irq_cnt - base, 3);
    rx(8'h08, 2'b00); rx(8'h01, 2'b00);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst");

    // Retry exhaustion: FE instead of FA three times.
    do_reset();
    mouse_cmd(8'hFF, 8'hFE);
    mouse_cmd(8'hFF, 8'hFE);
    check_eq("retry_fail_early", init_fail, 0);
    mouse_cmd(8'hFF, 8'hFE);
    check_eq("retry_fail", init_fail, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (send_byte) n++;
    end
    check_eq("retry_no_send", n, 0);
    check_eq("retry_rden", read_enable, 0);
    check_eq("retry_done", init_done, 0);
    check_eq("retry_fail_sticky", init_fail, 1);

`ifdef MOUSE_EXPLORER_EN
    // Explorer: second knock answers 04; nibble Z and extra buttons.
    do_reset();
    init_head(8'h03);
    knock(8'hC8, 8'hC8, 8'h50);
    mouse_cmd(8'hF2, 8'hFA);
    rx(8'h04, 2'b00);
    init_tail();
    check_eq("exp_id", device_id, 8'h04);
    packet4(8'h08, 8'h00, 8'h00, 8'h2E, 8'hFE);
    check_eq("exp_btn", buttons_ext, 2'b10);
    rx(8'h08, 2'b00); rx(8'h01, 2'b00);
    #3 rst_n = 1'b0;
    #1 check_all_zero("exp_midrst");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
